mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and load/store.
// Latches the winning request, waits for mem_ready, and aborts with an error on watchdog expiry.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_err,
  input  logic                  ls_req,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W/8-1:0]   ls_we,
  input  logic [DATA_W-1:0]     ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  ls_err,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int SW = DATA_W / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  state_t        state;
  logic          last_ls;
  logic [CW-1:0] wdog;
  logic          expire;

  // Ties go to whichever side did not win last time; gated by reset so no grant leaks out.
  assign if_gnt = rst_n && (state == IDLE) && if_req && (!ls_req || last_ls);
  assign ls_gnt = rst_n && (state == IDLE) && ls_req && (!if_req || !last_ls);

  // Expires on the cycle the count would reach TIMEOUT; a same-cycle mem_ready takes priority.
  assign expire = (TIMEOUT != 0) && !mem_ready && (wdog == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_ls   <= 1'b1;
      wdog      <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_wdata <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_err    <= 1'b0;
      ls_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (if_gnt) begin
            state     <= BUSY_IF;
            last_ls   <= 1'b0;
            mem_req   <= 1'b1;
            mem_addr  <= if_addr;
            mem_we    <= '0;
            mem_wdata <= '0;
            wdog      <= '0;
          end else if (ls_gnt) begin
            state     <= BUSY_LS;
            last_ls   <= 1'b1;
            mem_req   <= 1'b1;
            mem_addr  <= ls_addr;
            mem_we    <= ls_we;
            mem_wdata <= ls_wdata;
            wdog      <= '0;
          end
        end
        BUSY_IF, BUSY_LS: begin
          if (mem_ready || expire) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (state == BUSY_IF) begin
              if_rvalid <= 1'b1;
              if_err    <= !mem_ready;
              if_rdata  <= mem_ready ? mem_rdata : '0;
            end else begin
              ls_rvalid <= 1'b1;
              ls_err    <= !mem_ready;
              ls_rdata  <= (mem_ready && (mem_we == SW'(0))) ? mem_rdata : '0;
            end
          end else if (TIMEOUT != 0) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grants, bus activity
// and completions; a separate monitor pops predicted completions and compares them.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, SW = DW / 8, T = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req = 0, ls_req = 0, mem_ready = 0;
  logic [AW-1:0] if_addr = 0, ls_addr = 0;
  logic [SW-1:0] ls_we = 0;
  logic [DW-1:0] ls_wdata = 0, mem_rdata = 0;
  logic          if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_req;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_we;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct { int own; int cyc; logic [DW-1:0] data; logic err; } resp_t;
  resp_t q[$];

  int compared = 0, mismatched = 0;
  int cyc = 0;

  // Requester state: a pending request holds its fields until granted.
  logic          pend [2];
  logic [AW-1:0] paddr [2];
  logic [SW-1:0] pwe;
  logic [DW-1:0] pwd;

  // Model of the current access: grant cycle, cycle mem_ready is driven, last busy cycle.
  int last = 1, free_at = 0, g_cyc = -10, rdy_cyc = -10, done_cyc = -10;
  logic [DW-1:0] plan_rd, e_wd;
  logic [AW-1:0] e_addr;
  logic [SW-1:0] e_we;
  int e_own = 0;
  int req_pct = 0, force_wait = -1;
  logic force_rd = 0;
  logic [DW-1:0] forced_rd = 0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", n, cyc, act, exp);
    end
  endtask

  task automatic step();
    int win, w;
    logic busy;
    @(posedge clk); cyc++; #1;
    for (int r = 0; r < 2; r++)
      if (!pend[r] && $urandom_range(99) < req_pct) begin
        pend[r]  = 1'b1;
        paddr[r] = $urandom;
        if (r == 1) begin
          pwe = ($urandom_range(1) == 1) ? SW'($urandom) : '0;
          pwd = $urandom;
        end
      end
    if_req = pend[0]; if_addr = paddr[0];
    ls_req = pend[1]; ls_addr = paddr[1]; ls_we = pwe; ls_wdata = pwd;
    win = -1;
    if (cyc >= free_at) begin
      if (pend[0] && pend[1]) win = 1 - last;
      else if (pend[0])       win = 0;
      else if (pend[1])       win = 1;
    end
    busy = (cyc > g_cyc) && (cyc <= done_cyc);
    mem_ready = 1'b0; mem_rdata = $urandom;
    if (busy && cyc == rdy_cyc) begin
      mem_ready = 1'b1; mem_rdata = plan_rd;
    end else if (!busy && $urandom_range(3) == 0) begin
      mem_ready = 1'b1;  // stray ready while idle must be ignored
    end
    @(negedge clk);
    chk("if_gnt", if_gnt, win == 0);
    chk("ls_gnt", ls_gnt, win == 1);
    chk("mem_req", mem_req, busy);
    if (busy) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, e_we);
      if (e_own == 1) chk("mem_wdata", mem_wdata, e_wd);
    end
    if (win >= 0) begin
      w = (force_wait >= 0) ? force_wait : $urandom_range(T + 1);
      plan_rd = force_rd ? forced_rd : DW'($urandom);
      e_own = win; e_addr = paddr[win];
      e_we  = (win == 1) ? pwe : '0;
      e_wd  = pwd;
      g_cyc = cyc;
      if (w < T) begin
        rdy_cyc  = cyc + w + 1;
        done_cyc = rdy_cyc;
        q.push_back('{win, done_cyc + 1, (win == 1 && pwe != 0) ? DW'(0) : plan_rd, 1'b0});
      end else begin
        rdy_cyc  = -10;
        done_cyc = cyc + T;
        q.push_back('{win, done_cyc + 1, DW'(0), 1'b1});
      end
      free_at = done_cyc + 1;
      last = win;
      pend[win] = 1'b0;
    end
  endtask

  task automatic drain();
    req_pct = 0;
    for (int i = 0; i < 200 && (pend[0] || pend[1] || cyc <= free_at); i++) step();
    chk("drain_done", pend[0] | pend[1] | (cyc <= free_at), 0);
  endtask

  // Two reset cycles; requests are held high to show grants stay low under reset.
  task automatic reset_seq();
    @(posedge clk); cyc++; #1;
    rst_n = 1'b0; if_req = 1'b1; ls_req = 1'b1; mem_ready = 1'b0;
    q.delete();
    @(posedge clk); cyc++; #1;
    mem_ready = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    chk("rst_ctrl", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err, mem_req}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); cyc++; #1;
    rst_n = 1'b1; if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
    pend[0] = 0; pend[1] = 0; last = 1; free_at = cyc;
    g_cyc = -10; rdy_cyc = -10; done_cyc = -10;
  endtask

  // Monitor: every completion pulse must match the oldest predicted response.
  initial begin
    resp_t e;
    int own;
    forever begin
      @(negedge clk);
      if (if_rvalid === 1'b1 && ls_rvalid === 1'b1) begin
        compared++; mismatched++;
        $display("FAIL both_rvalid: cycle %0d got if_rvalid=1 ls_rvalid=1 expected at most one", cyc);
      end else if (if_rvalid === 1'b1 || ls_rvalid === 1'b1) begin
        own = (ls_rvalid === 1'b1) ? 1 : 0;
        if (q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_rvalid: cycle %0d got rvalid from %0d expected none", cyc, own);
        end else begin
          e = q.pop_front();
          chk("resp_owner", own, e.own);
          chk("resp_cycle", cyc, e.cyc);
          chk("resp_rdata", own == 1 ? ls_rdata : if_rdata, e.data);
          chk("resp_err", own == 1 ? ls_err : if_err, e.err);
        end
      end
    end
  end

  initial begin
    pend[0] = 0; pend[1] = 0; paddr[0] = 0; paddr[1] = 0; pwe = 0; pwd = 0;
    reset_seq();

    // Both requesters always pending, one wait state: IF, LS, IF, LS every 3 cycles.
    req_pct = 100; force_wait = 1;
    repeat (14) step();
    drain();

    force_wait = -1; req_pct = 40;
    repeat (400) step();
    drain();

    // Zero-wait fetch.
    force_wait = 0; force_rd = 1; forced_rd = 32'hDEADBEEF;
    pend[0] = 1; paddr[0] = 32'h100;
    drain();
    force_rd = 0;

    // Store with partial strobes.
    force_wait = 2;
    pend[1] = 1; paddr[1] = 32'h2000; pwe = 4'b0011; pwd = 32'h12345678;
    drain();

    // Hung load times out; ready in the last allowed cycle still completes normally.
    pwe = 0;
    force_wait = T;     pend[1] = 1; paddr[1] = 32'h40; drain();
    force_wait = T - 1; pend[1] = 1; paddr[1] = 32'h44; drain();

    // Request dropped right after the grant still completes exactly once.
    force_wait = 2; pend[1] = 1; paddr[1] = 32'h80;
    drain();

    // Reset during the second wait-state cycle of a load, then a tie grants IF first.
    force_wait = 9; pend[1] = 1; paddr[1] = 32'h300;
    step(); step();
    reset_seq();
    repeat (3) step();
    force_wait = 0; pend[0] = 1; pend[1] = 1; paddr[0] = 32'h500; paddr[1] = 32'h600;
    drain();

    force_wait = -1; req_pct = 60;
    repeat (300) step();
    drain();
    repeat (3) step();
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
